// File: rtl/wb_merge.sv
// wb_merge: arbitrates pipeline and multi-cycle producer writes onto the
// single registered register-file write port, with starvation stall request.
module wb_merge #(
    parameter int DW        = 32,
    parameter int NCH       = 4,
    parameter int STALL_MAX = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic [5*NCH-1:0]       in_addr,
    input  logic [DW*NCH-1:0]      in_data,
    output logic                   RFWr_WB,
    output logic [4:0]             RegAddr_WB,
    output logic [DW-1:0]          RegWriteData_WB,
    output logic                   stall_req,
    output logic [$clog2(NCH)-1:0] grant_ch
);
    localparam int CW = $clog2(NCH);
    localparam int WW = $clog2(STALL_MAX + 1);

    logic [NCH-1:0] elig, disc;
    logic           busy, found, gr_hi;
    logic [CW:0]    idx;
    logic [CW-1:0]  gsel;
    logic [CW-1:0]  rr_q, rr_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic           wr_q, wr_d;
    logic [4:0]     addr_q, addr_d;
    logic [DW-1:0]  data_q, data_d;
    logic [CW-1:0]  ch_q, ch_d;

    always_comb begin
        elig = '0;
        disc = '0;
        for (int i = 0; i < NCH; i++) begin
            disc[i] = in_valid[i] & ~(|in_addr[5*i +: 5]);
            if (i != 0)
                elig[i] = in_valid[i] & (|in_addr[5*i +: 5]);
        end
    end

    assign busy = in_valid[0] & (|in_addr[4:0]);

    // Round-robin walk from rr_q, wrapping past NCH-1 back to channel 1.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = '0;
        for (int k = 0; k < NCH - 1; k++) begin
            idx = {1'b0, rr_q} + (CW+1)'(k);
            if (idx >= (CW+1)'(NCH))
                idx = idx - (CW+1)'(NCH - 1);
            if (!found && elig[idx[CW-1:0]]) begin
                found = 1'b1;
                gsel  = idx[CW-1:0];
            end
        end
    end

    assign gr_hi = found & ~busy;

    always_comb begin
        in_ready    = disc;
        in_ready[0] = 1'b1;
        if (gr_hi)
            in_ready[gsel] = 1'b1;
    end

    always_comb begin
        rr_d   = rr_q;
        wait_d = wait_q;
        wr_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        ch_d   = ch_q;
        if (busy) begin
            wr_d   = 1'b1;
            addr_d = in_addr[4:0];
            data_d = in_data[DW-1:0];
            ch_d   = '0;
            if (|elig && wait_q != WW'(STALL_MAX))
                wait_d = wait_q + 1'b1;
        end else if (gr_hi) begin
            wr_d   = 1'b1;
            ch_d   = gsel;
            wait_d = '0;
            rr_d   = (gsel == CW'(NCH - 1)) ? CW'(1) : gsel + 1'b1;
            for (int i = 1; i < NCH; i++) begin
                if (gsel == CW'(i)) begin
                    addr_d = in_addr[5*i +: 5];
                    data_d = in_data[DW*i +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q   <= CW'(1);
            wait_q <= '0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            ch_q   <= '0;
        end else begin
            rr_q   <= rr_d;
            wait_q <= wait_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ch_q   <= ch_d;
        end
    end

    assign RFWr_WB         = wr_q;
    assign RegAddr_WB      = addr_q;
    assign RegWriteData_WB = data_q;
    assign grant_ch        = ch_q;
    assign stall_req       = (wait_q == WW'(STALL_MAX));

endmodule

// File: tb/tb_wb_merge.sv
// tb_wb_merge: directed stimulus with scoreboard queues; monitors pop and
// compare each register-file write presented by the two merge instances.
module tb_wb_merge;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [1:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [3:0]   in_valid = '0;
    logic [3:0]   in_ready;
    logic [19:0]  in_addr = '0;
    logic [127:0] in_data = '0;
    logic         RFWr_WB, stall_req;
    logic [4:0]   RegAddr_WB;
    logic [31:0]  RegWriteData_WB;
    logic [1:0]   grant_ch;

    logic [1:0]   v2 = '0;
    logic [1:0]   r2;
    logic [9:0]   a2 = '0;
    logic [63:0]  d2 = '0;
    logic         wr2, st2;
    logic [4:0]   ra2;
    logic [31:0]  rd2;
    logic [0:0]   gc2;

    exp_t q1[$];
    exp_t q2[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    wb_merge #(.DW(32), .NCH(4), .STALL_MAX(8)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .RFWr_WB(RFWr_WB), .RegAddr_WB(RegAddr_WB),
        .RegWriteData_WB(RegWriteData_WB),
        .stall_req(stall_req), .grant_ch(grant_ch)
    );

    wb_merge #(.DW(32), .NCH(2), .STALL_MAX(1)) u_dut2 (
        .clk(clk), .reset(reset),
        .in_valid(v2), .in_ready(r2),
        .in_addr(a2), .in_data(d2),
        .RFWr_WB(wr2), .RegAddr_WB(ra2),
        .RegWriteData_WB(rd2),
        .stall_req(st2), .grant_ch(gc2)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int i, input logic v, input logic [4:0] a,
                          input logic [31:0] d);
        in_valid[i]       = v;
        in_addr[5*i +: 5] = a;
        in_data[32*i +: 32] = d;
    endtask

    task automatic push1(input logic [4:0] a, input logic [31:0] d,
                         input logic [1:0] c);
        q1.push_back('{a: a, d: d, c: c});
    endtask

    task automatic push2(input logic [4:0] a, input logic [31:0] d,
                         input logic [1:0] c);
        q2.push_back('{a: a, d: d, c: c});
    endtask

    // One cycle: check combinational ready/stall mid-cycle, then advance.
    task automatic step(input logic [3:0] er, input logic es,
                        input logic [1:0] er2, input logic es2);
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(er));
        chk("stall_req", 64'(stall_req), 64'(es));
        chk("in_ready2", 64'(r2), 64'(er2));
        chk("stall_req2", 64'(st2), 64'(es2));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && RFWr_WB) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=%0h required=none",
                         RegAddr_WB);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("waddr", 64'(RegAddr_WB), 64'(e.a));
                chk("wdata", 64'(RegWriteData_WB), 64'(e.d));
                chk("wch", 64'(grant_ch), 64'(e.c));
            end
        end
    end

    always @(negedge clk) begin
        if (reset && wr2) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write2 actual=%0h required=none",
                         ra2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("waddr2", 64'(ra2), 64'(e.a));
                chk("wdata2", 64'(rd2), 64'(e.d));
                chk("wch2", 64'(gc2), 64'(e.c));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b0;
        #1;
        chk("rst_wr", 64'(RFWr_WB), 64'd0);
        chk("rst_addr", 64'(RegAddr_WB), 64'd0);
        chk("rst_data", 64'(RegWriteData_WB), 64'd0);
        chk("rst_gch", 64'(grant_ch), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single channel-0 write.
        set_ch(0, 1'b1, 5'd5, 32'h1234);
        push1(5'd5, 32'h1234, 2'd0);
        step(4'b0001, 1'b0, 2'b01, 1'b0);
        set_ch(0, 1'b0, 5'd0, 32'h0);
        step(4'b0001, 1'b0, 2'b01, 1'b0);

        // Round robin across three producers.
        set_ch(1, 1'b1, 5'd8, 32'hA1);
        set_ch(2, 1'b1, 5'd9, 32'hA2);
        set_ch(3, 1'b1, 5'd10, 32'hA3);
        push1(5'd8, 32'hA1, 2'd1);
        step(4'b0011, 1'b0, 2'b01, 1'b0);
        set_ch(1, 1'b0, 5'd0, 32'h0);
        push1(5'd9, 32'hA2, 2'd2);
        step(4'b0101, 1'b0, 2'b01, 1'b0);
        set_ch(2, 1'b0, 5'd0, 32'h0);
        push1(5'd10, 32'hA3, 2'd3);
        step(4'b1001, 1'b0, 2'b01, 1'b0);
        // Pointer wrapped to 1: ch1 beats ch3.
        set_ch(1, 1'b1, 5'd14, 32'hB1);
        set_ch(3, 1'b1, 5'd15, 32'hB3);
        push1(5'd14, 32'hB1, 2'd1);
        step(4'b0011, 1'b0, 2'b01, 1'b0);
        set_ch(1, 1'b0, 5'd0, 32'h0);
        push1(5'd15, 32'hB3, 2'd3);
        step(4'b1001, 1'b0, 2'b01, 1'b0);
        set_ch(3, 1'b0, 5'd0, 32'h0);

        // Starvation: ch0 busy, ch2 blocked.
        set_ch(2, 1'b1, 5'd7, 32'hC7);
        for (int n = 1; n <= 10; n++) begin
            set_ch(0, 1'b1, 5'd4, 32'h400 + 32'(n));
            push1(5'd4, 32'h400 + 32'(n), 2'd0);
            step(4'b0001, n >= 9, 2'b01, 1'b0);
        end
        set_ch(0, 1'b0, 5'd0, 32'h0);
        push1(5'd7, 32'hC7, 2'd2);
        step(4'b0101, 1'b1, 2'b01, 1'b0);
        set_ch(2, 1'b0, 5'd0, 32'h0);
        step(4'b0001, 1'b0, 2'b01, 1'b0);

        // Discards alongside a channel-0 write; pointer stays at 3.
        set_ch(0, 1'b1, 5'd3, 32'hD3);
        set_ch(1, 1'b1, 5'd0, 32'hDEAD);
        set_ch(2, 1'b1, 5'd0, 32'hBEEF);
        push1(5'd3, 32'hD3, 2'd0);
        step(4'b0111, 1'b0, 2'b01, 1'b0);
        set_ch(0, 1'b0, 5'd0, 32'h0);
        set_ch(2, 1'b0, 5'd0, 32'h0);
        set_ch(1, 1'b1, 5'd11, 32'hE11);
        set_ch(3, 1'b1, 5'd12, 32'hE12);
        push1(5'd12, 32'hE12, 2'd3);
        step(4'b1001, 1'b0, 2'b01, 1'b0);
        set_ch(3, 1'b0, 5'd0, 32'h0);
        push1(5'd11, 32'hE11, 2'd1);
        step(4'b0011, 1'b0, 2'b01, 1'b0);
        set_ch(1, 1'b0, 5'd0, 32'h0);

        // Reset while ch1 waits with five blocked cycles counted.
        set_ch(1, 1'b1, 5'd13, 32'h13D);
        for (int n = 1; n <= 5; n++) begin
            set_ch(0, 1'b1, 5'd6, 32'hF0 + 32'(n));
            push1(5'd6, 32'hF0 + 32'(n), 2'd0);
            step(4'b0001, 1'b0, 2'b01, 1'b0);
        end
        reset = 1'b0;
        void'(q1.pop_back());
        #1;
        chk("mid_rst_wr", 64'(RFWr_WB), 64'd0);
        chk("mid_rst_addr", 64'(RegAddr_WB), 64'd0);
        chk("mid_rst_data", 64'(RegWriteData_WB), 64'd0);
        chk("mid_rst_gch", 64'(grant_ch), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            set_ch(0, 1'b1, 5'd6, 32'h600 + 32'(n));
            push1(5'd6, 32'h600 + 32'(n), 2'd0);
            step(4'b0001, 1'b0, 2'b01, 1'b0);
        end
        set_ch(0, 1'b0, 5'd0, 32'h0);
        push1(5'd13, 32'h13D, 2'd1);
        step(4'b0011, 1'b0, 2'b01, 1'b0);
        set_ch(1, 1'b0, 5'd0, 32'h0);
        step(4'b0001, 1'b0, 2'b01, 1'b0);

        // Two-channel build with STALL_MAX=1.
        v2 = 2'b11;
        a2 = {5'd2, 5'd1};
        d2 = {32'hE2, 32'hE1};
        push2(5'd1, 32'hE1, 2'd0);
        step(4'b0001, 1'b0, 2'b01, 1'b0);
        v2 = 2'b10;
        push2(5'd2, 32'hE2, 2'd1);
        step(4'b0001, 1'b0, 2'b11, 1'b1);
        v2 = 2'b00;
        step(4'b0001, 1'b0, 2'b01, 1'b0);
        v2 = 2'b10;
        a2 = {5'd3, 5'd0};
        d2 = {32'hE3, 32'h0};
        push2(5'd3, 32'hE3, 2'd1);
        step(4'b0001, 1'b0, 2'b11, 1'b0);
        v2 = 2'b00;
        step(4'b0001, 1'b0, 2'b01, 1'b0);
        step(4'b0001, 1'b0, 2'b01, 1'b0);

        chk("q1_left", 64'(q1.size()), 64'd0);
        chk("q2_left", 64'(q2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_merge.md
# wb_merge

Parametrised writeback merge stage. It collects register-file write requests from the in-order pipeline (channel 0) and from NCH-1 multi-cycle producers such as mul/div or CP0 sequencers (channels 1..NCH-1), and arbitrates them onto the single register-file write port. The output is registered and also serves as the forwarding source. A starvation counter raises a stall request toward the pipeline when a multi-cycle result has waited too long.

## Interface
- DW, 32, data width of each write value
- NCH, 4, total channels (≥2); channel 0 is the pipeline, channels 1..NCH-1 are multi-cycle producers
- STALL_MAX, 8, number of blocked cycles before stall_req asserts (≥1)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  NCH  per-channel request valid
- in_ready  out  NCH  per-channel accept; a request transfers when valid & ready in the same cycle
- in_addr  in  5*NCH  destination register, channel i at bits [5i+4:5i]
- in_data  in  DW*NCH  write value, channel i at bits [DW*i+DW-1:DW*i]
- RFWr_WB  out  1  register-file write enable (registered)
- RegAddr_WB  out  5  write address (registered)
- RegWriteData_WB  out  DW  write data (registered)
- stall_req  out  1  request that the pipeline present no channel-0 write next cycle
- grant_ch  out  clog2(NCH)  channel that produced the current RFWr_WB (registered)

## Operation
- Channel 0 has fixed top priority. in_ready[0] is constantly 1, and channel 0 is never back-pressured.
- Discard rule: any channel with valid=1 and addr=0 gets ready=1 in the same cycle. It consumes no port slot and produces no write. Any number of channels may discard simultaneously.
- Port is busy when in_valid[0]=1 and in_addr[0]≠0. When busy, in_ready[i]=0 for every i≥1 with a nonzero address.
- Port is free otherwise. Round-robin among channels i≥1 with valid=1 and addr≠0:
  - Search starts at rr_ptr and wraps from NCH-1 back to 1.
  - The first eligible channel gets ready=1; all others get 0.
- rr_ptr update: on a grant to channel g≥1, rr_ptr becomes g+1, wrapping NCH-1 to 1. Otherwise rr_ptr holds.
- Output register:
  - On any port grant (channel 0 or g≥1), RFWr_WB=1 next cycle with that channel's addr and data, and grant_ch=channel.
  - With no grant, RFWr_WB=0 and RegAddr_WB/RegWriteData_WB/grant_ch hold their previous values.
- Starvation counter wait_cnt (0..STALL_MAX, saturating):
  - Increments in each cycle where some channel i≥1 is eligible but the port is busy.
  - Clears on any grant to a channel ≥1.
  - Holds otherwise.
  - stall_req = (wait_cnt == STALL_MAX), decoded from the register.
- stall_req is advisory. If the pipeline still drives a channel-0 write while stall_req=1, channel 0 still wins and wait_cnt stays saturated.
- Producers must hold valid, addr and data stable until accepted. Dropping valid before acceptance is a protocol error and is not checked.

## Timing
- Reset values: RFWr_WB=0, RegAddr_WB=0, RegWriteData_WB=0, grant_ch=0, stall_req=0, wait_cnt=0, rr_ptr=1. in_ready follows combinationally from inputs and state, so in_ready[0]=1 even during reset.
- Latency: a request accepted in cycle t appears on the RF port in cycle t+1 for exactly one cycle.
- in_ready is combinational from in_valid, in_addr and state. There is no combinational path from in_data to any output.
- Throughput: one write per cycle. With channel 0 idle, k contending producers each receive one grant every k cycles.
- stall_req rises in the cycle after the STALL_MAX-th consecutive blocked cycle. It falls in the cycle after the first grant to a channel ≥1.
- Reset asserted mid-operation clears all state immediately. Requests pending at that moment are lost, and producers must reissue them after reset deasserts.
- Simultaneous events: a channel-0 write plus discards on other channels in the same cycle is legal. A grant and a counter increment cannot coincide.

## Test plan
- Reset, then ch0 valid addr=5 data=0x1234 for one cycle → next cycle RFWr_WB=1, RegAddr_WB=5, RegWriteData_WB=0x1234, grant_ch=0; the following cycle RFWr_WB=0.
- ch0 idle; ch1, ch2, ch3 held valid (addr 8/9/10) → grants in order 1,2,3 on consecutive cycles, each write appearing one cycle later; rr_ptr wraps to 1.
- ch0 valid every cycle with addr=4; ch2 valid addr=7 → in_ready[2]=0 throughout; stall_req=1 after 8 blocked cycles. Drop ch0 → ch2 written next cycle, stall_req=0 one cycle after the grant.
- ch0 addr=3 and ch1 addr=0 both valid → in_ready[1]=1 (discard); only reg 3 is written; rr_ptr unchanged.
- Assert reset while ch1 is waiting with wait_cnt=5 → all outputs 0 and wait_cnt=0 at once; after release, ch1 is granted within one cycle of ch0 going idle.
- NCH=2, STALL_MAX=1 build: one blocked cycle → stall_req=1 on the next cycle; rr_ptr stays 1.
